// File: rtl/iccm_boot_pkg.sv
// Shared types and constants for the ICCM boot loader controller.
package iccm_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHK,
        RUN,
        ERR
    } boot_state_e;

    localparam int LenBytes  = 2;
    localparam int WordBytes = 4;

endpackage

// File: rtl/iccm_word_pack.sv
// Byte-to-word packer: gathers four bytes little-endian and flags the completing byte.
module iccm_word_pack
    import iccm_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;

    // The fourth byte is not stored; it is merged combinationally so the word is ready on its strobe.
    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 2'(WordBytes - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else if (clear_i) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else if (byte_valid_i) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {byte_i, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/iccm_boot_ctrl.sv
// ICCM port sequencer: loads a byte-stream image into ICCM, then hands the port to the fetch path.
// Optional ICCM_BOOT_CHKSUM_EN adds a trailing 32-bit sum word that must match before release.
module iccm_boot_ctrl
    import iccm_boot_pkg::*;
#(
    parameter int          Aw         = 12,
    parameter int          Dw         = 32,
    parameter logic [31:0] TimeoutCyc = 32'd1_000_000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          boot_en_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    input  logic          host_req_i,
    input  logic [Aw-1:0] host_addr_i,
    output logic          host_gnt_o,
    output logic          iccm_req_o,
    output logic          iccm_we_o,
    output logic [Aw-1:0] iccm_addr_o,
    output logic [Dw-1:0] iccm_wdata_o,
    output logic          core_rst_no,
    output logic          done_o,
    output logic          err_o
);

    boot_state_e   state_q, state_d;
    logic [7:0]    len_lo_q;
    logic          len_cnt_q;
    logic [Aw:0]   words_left_q;
    logic [Aw-1:0] wr_ptr_q;
    logic [Dw-1:0] data_q;
    logic [31:0]   idle_q;
`ifdef ICCM_BOOT_CHKSUM_EN
    logic [Dw-1:0] sum_q;
`endif

    logic [15:0] len_value;
    logic        len_last, len_too_big, timeout, pack_active, word_valid;
    logic [31:0] pack_word;

    assign len_value   = {rx_byte_i, len_lo_q};
    assign len_last    = rx_valid_i && (len_cnt_q == 1'(LenBytes - 1));
    assign len_too_big = {1'b0, len_value} > 17'(2 ** Aw);
    assign timeout     = idle_q >= TimeoutCyc;
    assign pack_active = (state_q == DATA) || (state_q == WRITE) || (state_q == CHK);

    iccm_word_pack u_pack (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (!pack_active),
        .byte_valid_i (rx_valid_i),
        .byte_i       (rx_byte_i),
        .word_o       (pack_word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = boot_en_i ? LEN : RUN;
            LEN: begin
                if (timeout) begin
                    state_d = ERR;
                end else if (len_last) begin
                    if (len_too_big) begin
                        state_d = ERR;
                    end else if (len_value == 16'd0) begin
`ifdef ICCM_BOOT_CHKSUM_EN
                        state_d = CHK;
`else
                        state_d = RUN;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (timeout) begin
                    state_d = ERR;
                end else if (word_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (words_left_q == (Aw+1)'(1)) begin
`ifdef ICCM_BOOT_CHKSUM_EN
                    state_d = CHK;
`else
                    state_d = RUN;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            CHK: begin
`ifdef ICCM_BOOT_CHKSUM_EN
                if (timeout) begin
                    state_d = ERR;
                end else if (word_valid) begin
                    state_d = (pack_word == sum_q) ? RUN : ERR;
                end
`else
                state_d = ERR;
`endif
            end
            RUN:     state_d = RUN;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Loader datapath: length capture, word staging, write pointer and byte-gap watchdog.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_lo_q     <= '0;
            len_cnt_q    <= 1'b0;
            words_left_q <= '0;
            wr_ptr_q     <= '0;
            data_q       <= '0;
            idle_q       <= '0;
`ifdef ICCM_BOOT_CHKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            if (state_q == LEN && rx_valid_i) begin
                len_cnt_q <= len_cnt_q + 1'b1;
                if (len_last) begin
                    words_left_q <= (Aw+1)'(len_value);
                end else begin
                    len_lo_q <= rx_byte_i;
                end
            end
            if (state_q == DATA && word_valid) begin
                data_q <= pack_word;
            end
            if (state_q == WRITE) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                words_left_q <= words_left_q - 1'b1;
`ifdef ICCM_BOOT_CHKSUM_EN
                sum_q        <= sum_q + data_q;
`endif
            end
            if (state_q == LEN || pack_active) begin
                idle_q <= rx_valid_i ? '0 : idle_q + 32'd1;
            end else begin
                idle_q <= '0;
            end
        end
    end

    always_comb begin
        host_gnt_o   = 1'b0;
        iccm_req_o   = 1'b0;
        iccm_we_o    = 1'b0;
        iccm_addr_o  = '0;
        iccm_wdata_o = '0;
        core_rst_no  = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        unique case (state_q)
            WRITE: begin
                iccm_req_o   = 1'b1;
                iccm_we_o    = 1'b1;
                iccm_addr_o  = wr_ptr_q;
                iccm_wdata_o = data_q;
            end
            RUN: begin
                host_gnt_o  = 1'b1;
                iccm_req_o  = host_req_i;
                iccm_addr_o = host_addr_i;
                core_rst_no = 1'b1;
                done_o      = 1'b1;
            end
            ERR:     err_o = 1'b1;
            default: ;
        endcase
    end

endmodule
